// File: rtl/ssd_time_display.sv
// ssd_time_display
// Serial double-dabble binary-to-BCD converter feeding an 8-digit,
// active-low seven-segment scan driver that shows the held count as SS.mmm.
// Optional build macro: SSD_LZ_BLANK_EN compiles in leading-zero blanking
// of the digits above the decimal point.
module ssd_time_display #(
  parameter int BIN_WIDTH = 16,
  parameter int DP_DIGIT  = 3
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 scanTick,
  input  logic [BIN_WIDTH-1:0] valueIn,
  input  logic                 load,
  input  logic                 blank,
  output logic                 busy,
  output logic                 done,
  output logic [6:0]           ssdCathode,
  output logic [7:0]           ssdAnode,
  output logic                 DP
);

  localparam int CNT_W = $clog2(BIN_WIDTH + 1);
  localparam int BCD_W = 20;
  localparam int WIDE_W = BCD_W + BIN_WIDTH;

  typedef enum logic {IDLE, CONV} state_t;

  state_t               state, state_n;
  logic                 start, step, last;
  logic [BIN_WIDTH-1:0] shreg, shreg_n;
  logic [BCD_W-1:0]     bcd, bcd_n;
  logic [CNT_W-1:0]     cnt;
  logic [BCD_W-1:0]     dig;
  logic [WIDE_W-1:0]    wide;
  logic [2:0]           scan;
  logic [7:0]           dark;
  logic [3:0]           cur_digit;

  // Double-dabble correction: any nibble of 5 or more gets +3 before the shift.
  function automatic logic [BCD_W-1:0] add3(input logic [BCD_W-1:0] b);
    logic [BCD_W-1:0] r;
    r = b;
    for (int i = 0; i < 5; i++) begin
      if (b[4*i +: 4] >= 4'd5) r[4*i +: 4] = b[4*i +: 4] + 4'd3;
    end
    return r;
  endfunction

  // Active-low segment pattern, bit0 = a ... bit6 = g.
  function automatic logic [6:0] seg7(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'h40;
      4'd1:    s = 7'h79;
      4'd2:    s = 7'h24;
      4'd3:    s = 7'h30;
      4'd4:    s = 7'h19;
      4'd5:    s = 7'h12;
      4'd6:    s = 7'h02;
      4'd7:    s = 7'h78;
      4'd8:    s = 7'h00;
      4'd9:    s = 7'h10;
      default: s = 7'h7F;
    endcase
    return s;
  endfunction

  // Conversion FSM state register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_n;
  end

  // Next state and datapath strobes; load during CONV is simply dropped.
  always_comb begin
    state_n = state;
    start   = 1'b0;
    step    = 1'b0;
    last    = 1'b0;
    case (state)
      IDLE: begin
        if (load) begin
          start   = 1'b1;
          state_n = CONV;
        end
      end
      CONV: begin
        step = 1'b1;
        if (cnt == CNT_W'(1)) begin
          last    = 1'b1;
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // One correct-and-shift of {scratch, shift register}.
  always_comb begin
    wide    = {add3(bcd), shreg} << 1;
    bcd_n   = wide[WIDE_W-1:BIN_WIDTH];
    shreg_n = wide[BIN_WIDTH-1:0];
  end

  // Conversion datapath; dig only changes on the final shift so the display never sees partial values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      shreg <= '0;
      bcd   <= '0;
      cnt   <= '0;
      dig   <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      done <= 1'b0;
      if (start) begin
        shreg <= valueIn;
        bcd   <= '0;
        cnt   <= CNT_W'(BIN_WIDTH);
        busy  <= 1'b1;
      end else if (step) begin
        shreg <= shreg_n;
        bcd   <= bcd_n;
        cnt   <= cnt - CNT_W'(1);
        if (last) begin
          dig  <= bcd_n;
          done <= 1'b1;
          busy <= 1'b0;
        end
      end
    end
  end

  // Per-position darkness: positions 5..7 are always off, low positions optionally blanked as leading zeros.
  always_comb begin
    dark = 8'hE0;
`ifdef SSD_LZ_BLANK_EN
    begin
      logic seen;
      seen = 1'b0;
      for (int i = 4; i >= 0; i--) begin
        if (dig[4*i +: 4] != 4'd0) seen = 1'b1;
        if ((i > DP_DIGIT) && !seen) dark[i] = 1'b1;
      end
    end
`endif
  end

  // Digit currently addressed by the scan counter.
  always_comb begin
    case (scan)
      3'd0:    cur_digit = dig[3:0];
      3'd1:    cur_digit = dig[7:4];
      3'd2:    cur_digit = dig[11:8];
      3'd3:    cur_digit = dig[15:12];
      3'd4:    cur_digit = dig[19:16];
      default: cur_digit = 4'd0;
    endcase
  end

  // Scan driver: register outputs from the current position on each tick, then advance.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      scan       <= 3'd0;
      ssdAnode   <= 8'hFF;
      ssdCathode <= 7'h7F;
      DP         <= 1'b1;
    end else if (scanTick) begin
      scan <= scan + 3'd1;
      if (blank || dark[scan]) begin
        ssdAnode   <= 8'hFF;
        ssdCathode <= 7'h7F;
        DP         <= 1'b1;
      end else begin
        ssdAnode   <= ~(8'd1 << scan);
        ssdCathode <= seg7(cur_digit);
        DP         <= !((DP_DIGIT <= 4) && (scan == 3'(DP_DIGIT)));
      end
    end
  end

endmodule

// File: tb/tb_ssd_time_display.sv
// Testbench for ssd_time_display: a decimal reference model predicts each
// conversion's commit edge and each scanned display frame; monitors pop and
// compare those predictions against the DUT outputs.
module tb_ssd_time_display;

  localparam int BW  = 16;
  localparam int DPD = 3;

  logic          clk;
  logic          reset;
  logic          scanTick;
  logic [BW-1:0] valueIn;
  logic          load;
  logic          blank;
  logic          busy;
  logic          done;
  logic [6:0]    ssdCathode;
  logic [7:0]    ssdAnode;
  logic          DP;

  ssd_time_display #(.BIN_WIDTH(BW), .DP_DIGIT(DPD)) dut (
    .clk(clk), .reset(reset), .scanTick(scanTick), .valueIn(valueIn),
    .load(load), .blank(blank), .busy(busy), .done(done),
    .ssdCathode(ssdCathode), .ssdAnode(ssdAnode), .DP(DP)
  );

  typedef struct {
    logic [7:0] an;
    logic [6:0] ca;
    logic       dp;
  } disp_t;

  int    checks = 0;
  int    errors = 0;
  int    ecnt = 0;
  bit    pending = 0;
  int    pend_val = 0;
  int    commit_edge = 0;
  int    m_scan = 0;
  int    m_dig = 0;
  bit    tick_en = 0;
  int    done_q[$];
  disp_t disp_q[$];
  disp_t last;

  int         p10 [5] = '{1, 10, 100, 1000, 10000};
  logic [6:0] segt [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                            7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic disp_t mk(input logic [7:0] a, input logic [6:0] c, input logic d);
    disp_t r;
    r.an = a;
    r.ca = c;
    r.dp = d;
    return r;
  endfunction

  // What the display should show for scan position sc while holding decimal value val.
  function automatic disp_t expect_disp(input int sc, input int val, input bit blk);
    int d;
    if (blk || sc > 4) return mk(8'hFF, 7'h7F, 1'b1);
`ifdef SSD_LZ_BLANK_EN
    if (sc > DPD && val < p10[sc]) return mk(8'hFF, 7'h7F, 1'b1);
`endif
    d = (val / p10[sc]) % 10;
    return mk(~(8'd1 << sc), segt[d], (sc == DPD) ? 1'b0 : 1'b1);
  endfunction

  // Reference model: advances at every active edge from the inputs only.
  initial begin
    bit acc;
    last = mk(8'hFF, 7'h7F, 1'b1);
    forever begin
      @(posedge clk or negedge reset);
      if (!reset) begin
        m_scan  = 0;
        m_dig   = 0;
        pending = 0;
        done_q.delete();
        disp_q.delete();
        last = mk(8'hFF, 7'h7F, 1'b1);
      end else begin
        ecnt++;
        if (scanTick) begin
          disp_q.push_back(expect_disp(m_scan, m_dig, blank));
          m_scan = (m_scan + 1) % 8;
        end
        acc = load && !pending;
        if (pending && ecnt == commit_edge) begin
          m_dig   = pend_val;
          pending = 0;
        end
        if (acc) begin
          pending     = 1;
          pend_val    = int'(valueIn);
          commit_edge = ecnt + BW;
          done_q.push_back(commit_edge);
        end
      end
    end
  end

  // Monitor: compares DUT outputs against the model on the inactive edge.
  initial begin
    int e;
    forever begin
      @(negedge clk);
      if (!reset) begin
        chk("rst_anode", ssdAnode, 8'hFF);
        chk("rst_cathode", ssdCathode, 7'h7F);
        chk("rst_dp", DP, 1);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
      end else begin
        chk("busy", busy, pending);
        if (done) begin
          if (done_q.size() == 0) begin
            chk("done_unexpected", done, 0);
          end else begin
            e = done_q.pop_front();
            chk("done_edge", ecnt, e);
            chk("busy_in_done", busy, 0);
          end
        end else if (done_q.size() > 0 && ecnt >= done_q[0]) begin
          e = done_q.pop_front();
          chk("done_missing", 0, 1);
        end
        if (disp_q.size() > 0) last = disp_q.pop_front();
        chk("anode", ssdAnode, last.an);
        chk("cathode", ssdCathode, last.ca);
        chk("dp", DP, last.dp);
      end
    end
  end

  // Scan tick source: irregular single-cycle pulses.
  initial begin
    scanTick = 1'b0;
    forever begin
      @(negedge clk);
      scanTick = tick_en && ($urandom_range(0, 3) == 0);
    end
  end

  task automatic do_load(input int v);
    @(negedge clk);
    load    = 1'b1;
    valueIn = BW'(v);
    @(negedge clk);
    load = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    reset   = 1'b0;
    load    = 1'b0;
    blank   = 1'b0;
    valueIn = '0;
    idle(3);
    reset   = 1'b1;
    tick_en = 1'b1;
    idle(20);

    // Asynchronous reset mid-scan takes effect without a clock edge.
    #2 reset = 1'b0;
    #1;
    chk("async_anode", ssdAnode, 8'hFF);
    chk("async_cathode", ssdCathode, 7'h7F);
    chk("async_dp", DP, 1);
    chk("async_busy", busy, 0);
    idle(2);
    #2 reset = 1'b1;

    idle(30);
    do_load(1234);
    idle(70);
    do_load(65535);
    idle(70);

    // Load during a conversion is ignored.
    do_load(1234);
    idle(4);
    load = 1'b1; valueIn = BW'(9);
    @(negedge clk);
    load = 1'b0;
    idle(70);

    // Reset part-way through a conversion, then a clean conversion.
    do_load(4321);
    idle(7);
    #2 reset = 1'b0;
    idle(2);
    #2 reset = 1'b1;
    idle(40);
    do_load(500);
    idle(70);

    do_load(7);
    idle(70);
    do_load(0);
    idle(60);
    blank = 1'b1;
    idle(40);
    blank = 1'b0;
    idle(40);

    // Load held high: back-to-back conversions with changing data.
    for (int i = 0; i < 80; i++) begin
      @(negedge clk);
      load    = 1'b1;
      valueIn = BW'($urandom_range(0, 65535));
    end
    @(negedge clk);
    load = 1'b0;
    idle(60);

    // Random mix of loads, data and blanking.
    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      load    = ($urandom_range(0, 7) == 0);
      valueIn = BW'($urandom_range(0, 65535));
      blank   = ($urandom_range(0, 15) == 0);
    end
    @(negedge clk);
    load  = 1'b0;
    blank = 1'b0;
    idle(80);

    if (done_q.size() > 0) chk("done_outstanding", done_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ssd_time_display.md
# ssd_time_display

Sequential binary-to-BCD converter and 8-digit seven-segment scan driver for the reaction timer. It sits downstream of the reaction-timer FSM and replaces that FSM's inline display logic. It accepts a millisecond count with a load strobe, converts it by serial double-dabble, and holds the result. The held value is scanned onto the board display as `SS.mmm` using the shared 1 kHz tick from the clock divider.

## Interface
- `BIN_WIDTH`, 16: width of `valueIn`; legal range 4..16; the result is always 5 BCD digits.
- `DP_DIGIT`, 3: digit index (0 = rightmost) whose decimal point is lit.
- `clk` in 1: system clock; all logic is in this single domain.
- `reset` in 1: asynchronous, active-low; asserting it clears all state immediately.
- `scanTick` in 1: one-`clk`-wide enable pulse at 1 kHz from the clock divider.
- `valueIn` in BIN_WIDTH: unsigned millisecond count; sampled only on an accepted `load`.
- `load` in 1: conversion request; accepted only while idle.
- `blank` in 1: level input; forces the display dark while high.
- `busy` out 1: high while a conversion is running.
- `done` out 1: one-cycle pulse when the new digits are committed.
- `ssdCathode` out 7: active-low segments; bit0 = a … bit6 = g.
- `ssdAnode` out 8: active-low digit enables; bit i = digit i.
- `DP` out 1: active-low decimal point.

## Operation
- Conversion FSM has two states, IDLE and CONV.
- IDLE with `load`=1:
  - Capture `valueIn` into the shift register and clear the BCD scratch.
  - Set the shift counter to BIN_WIDTH, set `busy`=1, go to CONV.
- IDLE with `load`=0: hold state; no change to any register.
- CONV, each cycle:
  - Add 3 to every scratch BCD nibble that is ≥5.
  - Shift {scratch, shift register} left by 1 and decrement the counter.
- CONV on the final shift (counter reaches 0):
  - Write the post-shift scratch into the display digit register `dig[4:0]`.
  - Pulse `done`, clear `busy`, return to IDLE.
- `load` while in CONV is ignored and is not queued.
- The display keeps showing the previous `dig` until commit, so no partial values ever appear.
- Scan:
  - A 3-bit counter `scan` advances on `scanTick` and wraps 7→0.
  - On each tick, the outputs are registered from the current `scan`, then `scan` increments.
- Digit decode: 0..9 active-low hex is 40,79,24,30,19,12,02,78,00,10.
- Digits 0..4:
  - Anode bit `scan` is low, all other anode bits high.
  - Cathode is the decoded `dig[scan]`.
- `DP`=0 only when `scan`==DP_DIGIT and that digit is lit.
- Digits 5..7: `ssdAnode`=FF, `ssdCathode`=7F, `DP`=1.
- `blank`=1 at a tick: `ssdAnode`=FF, `ssdCathode`=7F, `DP`=1. The scan counter still advances.

## Timing
- Reset values:
  - Outputs: `busy`=0, `done`=0, `ssdAnode`=FF, `ssdCathode`=7F, `DP`=1.
  - Internal: `scan`=0, `dig`=0, state IDLE.
- Latency from load:
  - `load` is sampled at edge k; `busy` is high from edge k until edge k+BIN_WIDTH.
  - `done` is high for the cycle after edge k+BIN_WIDTH, with `busy`=0 in that same cycle.
- Back-to-back: `load` high in the `done` cycle is accepted, giving a new conversion every BIN_WIDTH+1 cycles.
- Display latency: outputs change only at `scanTick` edges, and a committed value appears no later than 8 ticks after commit.
- Simultaneous events:
  - A tick in the commit cycle uses the old `dig`.
  - `load` and `scanTick` in the same cycle are both serviced independently.
- Reset mid-conversion aborts the conversion. `dig` returns to 0 and no `done` is issued.

## Configuration
- `SSD_LZ_BLANK_EN` defined: leading-zero suppression is compiled in.
  - Digits above DP_DIGIT that sit above the most significant non-zero digit are blanked (anode off, cathode 7F).
  - Digits at or below DP_DIGIT are never blanked, so 0 shows as `0.000`.
- `SSD_LZ_BLANK_EN` undefined: all five digits are always shown, so 7 shows as `00.007`.

## Test plan
- Reset: hold `reset`=0 mid-scan -> `ssdAnode`=FF, `ssdCathode`=7F, `DP`=1, `busy`=0 immediately. After release, the first tick gives `ssdAnode`=FE, `ssdCathode`=40.
- Load 1234 -> `busy` high for 16 cycles, then `done` pulse. Ticks 0..4 give cathodes 19,30,24,79,40. At digit 3, `DP`=0 and `ssdAnode`=F7.
- Load 65535 -> displays `65.535`: digit cathodes 12,30,12,12,02, `DP` low only at digit 3. Digits 5..7 show anode FF.
- Pulse `load` (value 9) 5 cycles into a 1234 conversion -> ignored; `done` occurs at cycle 16 and `dig` equals 1234.
- Assert `reset` at cycle 8 of a conversion -> no `done`, `dig`=0. A fresh `load` of 500 then completes normally.
- Load 7 with `SSD_LZ_BLANK_EN` defined -> digit 4 anode stays off, digits 3..0 show `0.007`. Without the macro, digit 4 shows 40. Assert `blank`=1 -> `ssdAnode`=FF on every tick.
